// File: rtl/gemm_tile_scheduler_if.sv
// Host/PE/SRAM bundle for the GeMM tile scheduler.
// Member names match the scheduler's port list.
interface gemm_tile_scheduler_if #(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16
);
  logic                     start_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] K_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic                     input_valid_i;
  logic [AddrWidth-1:0]     sram_a_addr_o;
  logic [AddrWidth-1:0]     sram_b_addr_o;
  logic [AddrWidth-1:0]     sram_c_addr_o;
  logic                     sram_c_we_o;
  logic                     pe_valid_o;
  logic                     pe_init_save_o;
  logic                     pe_acc_clr_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output start_i, M_size_i, K_size_i, N_size_i,
    output input_valid_i,
    input  sram_a_addr_o, sram_b_addr_o,
    input  sram_c_addr_o, sram_c_we_o,
    input  pe_valid_o, pe_init_save_o, pe_acc_clr_o,
    input  busy_o, done_o
  );

  modport slave (
    input  start_i, M_size_i, K_size_i, N_size_i,
    input  input_valid_i,
    output sram_a_addr_o, sram_b_addr_o,
    output sram_c_addr_o, sram_c_we_o,
    output pe_valid_o, pe_init_save_o, pe_acc_clr_o,
    output busy_o, done_o
  );
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Output-stationary GeMM tile sequencer: m/n/k loops,
// A/B read addressing, PE controls and C write-back.
module gemm_tile_scheduler #(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16
) (
  input logic clk_i,
  input logic rst_ni,
  gemm_tile_scheduler_if.slave io
);
  localparam int SW = SizeAddrWidth;
  localparam int AW = AddrWidth;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e r_state, w_next;
  logic [SW-1:0] r_mt, r_kt, r_nt;
  logic [SW-1:0] r_m, r_n, r_k;
  logic [SW-1:0] r_m1, r_n1, r_k1;
  logic          r_v1, r_we;
  logic [AW-1:0] r_caddr;
  logic w_issue, w_zero, w_wr1;
  logic w_k_last, w_n_last, w_m_last, w_last;

  assign w_issue  = (r_state == S_RUN) && io.input_valid_i;
  assign w_k_last = (r_k == r_kt - SW'(1));
  assign w_n_last = (r_n == r_nt - SW'(1));
  assign w_m_last = (r_m == r_mt - SW'(1));
  assign w_last   = w_k_last && w_n_last && w_m_last;
  assign w_zero   = (io.M_size_i == '0) || (io.K_size_i == '0)
                 || (io.N_size_i == '0);
  assign w_wr1    = r_v1 && (r_k1 == r_kt - SW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // DRAIN ends once the write is out and stage 1 is empty
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (io.start_i) w_next = w_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_we && !r_v1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mt <= '0;
      r_kt <= '0;
      r_nt <= '0;
      r_m  <= '0;
      r_n  <= '0;
      r_k  <= '0;
    end else if (r_state == S_IDLE && io.start_i) begin
      r_mt <= io.M_size_i;
      r_kt <= io.K_size_i;
      r_nt <= io.N_size_i;
      r_m  <= '0;
      r_n  <= '0;
      r_k  <= '0;
    end else if (w_issue) begin
      if (!w_k_last) begin
        r_k <= r_k + SW'(1);
      end else begin
        r_k <= '0;
        if (!w_n_last) begin
          r_n <= r_n + SW'(1);
        end else begin
          r_n <= '0;
          r_m <= w_m_last ? '0 : r_m + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1    <= 1'b0;
      r_m1    <= '0;
      r_n1    <= '0;
      r_k1    <= '0;
      r_we    <= 1'b0;
      r_caddr <= '0;
    end else begin
      r_v1 <= w_issue;
      if (w_issue) begin
        r_m1 <= r_m;
        r_n1 <= r_n;
        r_k1 <= r_k;
      end
      r_we <= w_wr1;
      if (w_wr1)
        r_caddr <= AW'(r_m1) * AW'(r_nt) + AW'(r_n1);
    end
  end

  assign io.sram_a_addr_o  = AW'(r_m) * AW'(r_kt) + AW'(r_k);
  assign io.sram_b_addr_o  = AW'(r_k) * AW'(r_nt) + AW'(r_n);
  assign io.sram_c_addr_o  = r_caddr;
  assign io.sram_c_we_o    = r_we;
  assign io.pe_valid_o     = r_v1;
  assign io.pe_init_save_o = r_v1 && (r_k1 == '0);
  assign io.busy_o         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign io.pe_acc_clr_o   = !io.busy_o;
  assign io.done_o         = (r_state == S_DONE);
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler: directed runs,
// expected events queued up front, monitor pops on DUT strobes.
module tb_gemm_tile_scheduler;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int cyc = 0;
  int base = 0;
  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int rel;
  int prev_a = 0;
  int prev_b = 0;

  typedef struct {int c; int a; int b; int init;} iss_t;
  typedef struct {int c; int addr;} wr_t;
  iss_t q_iss[$];
  wr_t  q_wr[$];
  int   q_done[$];

  int a2[8]  = '{0, 1, 0, 1, 2, 3, 2, 3};
  int b2[8]  = '{0, 2, 1, 3, 0, 2, 1, 3};
  int i2[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
  int c2[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
  int c3[8]  = '{1, 4, 5, 6, 7, 8, 9, 10};
  int a5[6]  = '{0, 1, 2, 0, 1, 2};
  int b5[6]  = '{0, 2, 4, 1, 3, 5};
  int i5[6]  = '{1, 0, 0, 1, 0, 0};

  gemm_tile_scheduler_if #(.SizeAddrWidth(8), .AddrWidth(16)) bus ();

  gemm_tile_scheduler #(.SizeAddrWidth(8), .AddrWidth(16)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .io    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic unexpected(string nm, int r);
    checks++;
    errors++;
    $display("FAIL %s: got event at cycle %0d expected none", nm, r);
  endtask

  always @(negedge clk) begin
    rel = cyc - base;
    if (bus.pe_valid_o) begin
      if (q_iss.size() == 0) unexpected("pe_valid", rel);
      else begin
        iss_t e;
        e = q_iss.pop_front();
        check("issue_cycle", rel - 1, e.c);
        check("a_addr", prev_a, e.a);
        check("b_addr", prev_b, e.b);
        check("init_save", int'(bus.pe_init_save_o), e.init);
      end
    end
    if (bus.sram_c_we_o) begin
      if (q_wr.size() == 0) unexpected("c_we", rel);
      else begin
        wr_t w;
        w = q_wr.pop_front();
        check("c_we_cycle", rel, w.c);
        check("c_addr", int'(bus.sram_c_addr_o), w.addr);
      end
    end
    if (bus.done_o) begin
      if (q_done.size() == 0) unexpected("done", rel);
      else check("done_cycle", rel, q_done.pop_front());
    end
    if (bus.busy_o) busy_cnt++;
    prev_a = int'(bus.sram_a_addr_o);
    prev_b = int'(bus.sram_b_addr_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(string nm);
    check({nm, "_a"}, int'(bus.sram_a_addr_o), 0);
    check({nm, "_b"}, int'(bus.sram_b_addr_o), 0);
    check({nm, "_c"}, int'(bus.sram_c_addr_o), 0);
    check({nm, "_we"}, int'(bus.sram_c_we_o), 0);
    check({nm, "_pev"}, int'(bus.pe_valid_o), 0);
    check({nm, "_init"}, int'(bus.pe_init_save_o), 0);
    check({nm, "_clr"}, int'(bus.pe_acc_clr_o), 1);
    check({nm, "_busy"}, int'(bus.busy_o), 0);
    check({nm, "_done"}, int'(bus.done_o), 0);
  endtask

  task automatic check_drained(string nm, int exp_busy);
    check({nm, "_iss_left"}, q_iss.size(), 0);
    check({nm, "_wr_left"}, q_wr.size(), 0);
    check({nm, "_done_left"}, q_done.size(), 0);
    check({nm, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  task automatic run_op(string nm, int mt, int kt, int nt, int ncyc,
                        int slo, int shi, int ha, int hb,
                        int rs, int exp_busy);
    busy_cnt = 0;
    for (int r = 0; r < ncyc; r++) begin
      bus.start_i = (r == 0) || (r == rs);
      if (r == 0) begin
        bus.M_size_i = 8'(mt);
        bus.K_size_i = 8'(kt);
        bus.N_size_i = 8'(nt);
        base = cyc;
      end else if (r == rs) begin
        bus.M_size_i = 8'd2;
        bus.K_size_i = 8'd2;
        bus.N_size_i = 8'd2;
      end
      bus.input_valid_i = !(r >= slo && r <= shi);
      @(negedge clk);
      if (r >= slo && r <= shi) begin
        check({nm, "_hold_a"}, int'(bus.sram_a_addr_o), ha);
        check({nm, "_hold_b"}, int'(bus.sram_b_addr_o), hb);
      end
      step();
    end
    bus.start_i = 1'b0;
    bus.input_valid_i = 1'b1;
    check_drained(nm, exp_busy);
  endtask

  task automatic push_222(int sh);
    for (int i = 0; i < 8; i++)
      q_iss.push_back('{(sh != 0) ? c3[i] : c2[i], a2[i], b2[i], i2[i]});
    for (int i = 0; i < 4; i++)
      q_wr.push_back('{4 + 2 * i + sh, i});
    q_done.push_back(11 + sh);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.M_size_i = '0;
    bus.K_size_i = '0;
    bus.N_size_i = '0;
    bus.input_valid_i = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check_reset("reset");
    step();
    rst_ni = 1'b1;
    step();

    q_iss.push_back('{1, 0, 0, 1});
    q_wr.push_back('{3, 0});
    q_done.push_back(4);
    run_op("t111", 1, 1, 1, 6, -1, -1, 0, 0, -1, 3);

    push_222(0);
    run_op("t222", 2, 2, 2, 12, -1, -1, 0, 0, -1, 10);
    push_222(2);
    run_op("tstall", 2, 2, 2, 14, 2, 3, 1, 2, -1, 12);

    q_done.push_back(1);
    run_op("tzero", 3, 2, 0, 4, -1, -1, 0, 0, -1, 0);

    for (int i = 0; i < 6; i++)
      q_iss.push_back('{i + 1, a5[i], b5[i], i5[i]});
    q_wr.push_back('{5, 0});
    q_wr.push_back('{8, 1});
    q_done.push_back(9);
    run_op("trestart", 1, 3, 2, 10, -1, -1, 0, 0, 3, 8);

    busy_cnt = 0;
    q_iss.push_back('{1, 0, 0, 1});
    bus.M_size_i = 8'd2;
    bus.K_size_i = 8'd2;
    bus.N_size_i = 8'd2;
    bus.start_i = 1'b1;
    base = cyc;
    step();
    bus.start_i = 1'b0;
    repeat (2) step();
    rst_ni = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    step();
    rst_ni = 1'b1;
    repeat (6) step();
    check_drained("midrst", 2);

    push_222(0);
    run_op("tfresh", 2, 2, 2, 12, -1, -1, 0, 0, -1, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gemm_tile_scheduler.md
Name: gemm_tile_scheduler

Overview:
- Sequences the output-stationary M×N MAC-PE array over a large GeMM expressed in tiles: loop m-tile (outer), n-tile, k-tile (inner).
- Issues SRAM A/B tile-read addresses and drives the PE array's valid, init-save and accumulator-clear controls.
- Issues the SRAM C tile write; supports stalls on input data.
- Sits between the host start/done interface and the PE array plus the three tile SRAMs.

Parameters:
- SizeAddrWidth, 8, width of tile-count inputs and internal counters.
- AddrWidth, 16, width of SRAM tile addresses.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request, sampled only in IDLE
- M_size_i  in  SizeAddrWidth  number of m-tiles (Mt)
- K_size_i  in  SizeAddrWidth  number of k-tiles (Kt)
- N_size_i  in  SizeAddrWidth  number of n-tiles (Nt)
- input_valid_i  in  1  A/B read may issue this cycle; low = stall
- sram_a_addr_o  out  AddrWidth  A tile address
- sram_b_addr_o  out  AddrWidth  B tile address
- sram_c_addr_o  out  AddrWidth  C tile write address
- sram_c_we_o  out  1  C write enable
- pe_valid_o  out  1  A/B data on SRAM outputs is valid for the PEs
- pe_init_save_o  out  1  PE loads the product instead of accumulating
- pe_acc_clr_o  out  1  PE accumulator clear
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low (rst_ni).
- Reset values: all outputs 0, except pe_acc_clr_o = 1. FSM in IDLE; counters and latched sizes are 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 latches M/K/N sizes.
  - If any size is 0: go to DONE; no issue, no write.
  - Otherwise: go to RUN, with counters m=n=k=0.
- RUN: a read issues in every cycle where input_valid_i=1.
  - sram_a_addr_o = m*Kt + k.
  - sram_b_addr_o = k*Nt + n.
  - Both addresses are driven combinationally from the counters. Products are truncated mod 2^AddrWidth.
  - Addresses hold their value while stalled.
  - Counter advance on issue: k wraps at Kt-1 and increments n; n wraps at Nt-1 and increments m.
  - Issuing the last tuple (Mt-1, Nt-1, Kt-1) moves the FSM to DRAIN.
- SRAM read latency is 1 cycle. pe_valid_o is the issue strobe registered by one cycle.
- pe_init_save_o = pe_valid_o && (registered k == 0).
- Write path: one cycle after a pe_valid_o with registered k == Kt-1:
  - sram_c_we_o=1 for 1 cycle.
  - sram_c_addr_o = m*Nt + n of that tile, via a 2-stage pipeline of tile indices.
  - sram_c_addr_o holds its value otherwise.
- DRAIN waits for the final write, then goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o = (state == RUN || state == DRAIN).
- pe_acc_clr_o = !busy_o.
- Nominal timing, no stalls, P = Mt*Nt*Kt:
  - start in cycle 0.
  - Issue in cycles 1..P.
  - Last pe_valid_o in cycle P+1.
  - Last sram_c_we_o in cycle P+2.
  - done_o in cycle P+3.
  - busy_o high in cycles 1..P+2.
- Each stall cycle delays all subsequent events by one cycle. A stall never drops or duplicates a tuple.
- A stall during the last issue keeps the FSM in RUN.
- start_i while not in IDLE is ignored. Changing the size inputs mid-run has no effect.
- Back-to-back operation: start_i in the cycle after done_o is accepted.
- Reset mid-operation: immediate return to reset values. No write issues after reset deasserts until a new start.
- Kt=1: every pe_valid_o also has pe_init_save_o=1, and a write follows every issue.

Test Plan:
- Mt=Kt=Nt=1, start in cycle 0:
  - A/B addresses 0 in cycle 1.
  - pe_valid_o and pe_init_save_o in cycle 2.
  - sram_c_we_o with address 0 in cycle 3.
  - done_o in cycle 4.
- Mt=Kt=Nt=2, no stall:
  - A address sequence 0,1,0,1,2,3,2,3.
  - B address sequence 0,2,1,3,0,2,1,3.
  - C writes to 0,1,2,3 in cycles 4,6,8,10.
  - done_o in cycle 11.
- Same sizes, input_valid_i=0 in cycles 2 and 3:
  - Addresses hold their value.
  - Identical address and write sequences, each event from cycle 2 onward shifted by 2.
  - done_o in cycle 13.
- N_size_i=0 with start:
  - No pe_valid_o and no sram_c_we_o.
  - busy_o stays 0.
  - done_o in cycle 1.
- Mt=1, Kt=3, Nt=2, with start_i re-asserted in cycle 3 and sizes changed in cycle 3:
  - Ignored.
  - Writes to addresses 0 and 1 only.
  - done_o in cycle 9.
- Reset asserted in cycle 3 of a 2×2×2 run, then released:
  - Outputs return to reset values, with pe_acc_clr_o=1.
  - No write occurs.
  - A fresh start reproduces the nominal sequence.
